// File: rtl/condicionador_pkg.sv
// Shared definitions for the push-button conditioning stage: bus width and
// the FSM state codes shown on the debug display.
package condicionador_pkg;

  localparam int BOTOES_W = 4;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    FILTRA_PRESS = 4'd1,
    PRESSIONADO  = 4'd2,
    FILTRA_SOLTA = 4'd3
  } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer that brings asynchronous inputs into the clock domain.
// Both stages clear on reset, so a held button reappears as a fresh edge.
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_dado,
  output logic [WIDTH-1:0] o_dado
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sinc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sinc <= '0;
    end else begin
      r_meta <= i_dado;
      r_sinc <= r_meta;
    end
  end

  assign o_dado = r_sinc;

endmodule

// File: rtl/condicionador_botoes.sv
// Debounces the four game buttons and turns each accepted press into a held
// one-hot play code plus a single-cycle jogada_feita (or erro_multiplo) pulse.
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BOTOES_W-1:0] botoes,
  input  logic                habilita,
  input  logic                limpa,
  output logic [BOTOES_W-1:0] jogada,
  output logic                jogada_feita,
  output logic                erro_multiplo,
  output logic [3:0]          db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

  logic [BOTOES_W-1:0] w_sinc;

  estado_t             r_estado;
  estado_t             w_estadoProx;
  logic [BOTOES_W-1:0] r_cand;
  logic [BOTOES_W-1:0] w_candProx;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cntProx;
  logic [BOTOES_W-1:0] r_jogada;
  logic [BOTOES_W-1:0] w_jogadaProx;
  logic                r_jogadaFeita;
  logic                r_erroMultiplo;
  logic                w_aceita;
  logic                w_erro;

  sincronizador_2ff #(
    .WIDTH (BOTOES_W)
  ) u_sincronizador (
    .clock  (clock),
    .reset  (reset),
    .i_dado (botoes),
    .o_dado (w_sinc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_cand         <= '0;
      r_cnt          <= '0;
      r_jogada       <= '0;
      r_jogadaFeita  <= 1'b0;
      r_erroMultiplo <= 1'b0;
    end else begin
      r_estado       <= w_estadoProx;
      r_cand         <= w_candProx;
      r_cnt          <= w_cntProx;
      r_jogada       <= w_jogadaProx;
      r_jogadaFeita  <= w_aceita;
      r_erroMultiplo <= w_erro;
    end
  end

  // habilita only matters on the accept edge; a press that was ignored stays
  // in PRESSIONADO and can never fire later without a release.
  always_comb begin
    w_estadoProx = r_estado;
    w_candProx   = r_cand;
    w_cntProx    = r_cnt;
    w_aceita     = 1'b0;
    w_erro       = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_sinc != '0) begin
          w_candProx   = w_sinc;
          w_cntProx    = '0;
          w_estadoProx = FILTRA_PRESS;
        end
      end
      FILTRA_PRESS: begin
        if (w_sinc == '0) begin
          w_estadoProx = OCIOSO;
        end else if (w_sinc != r_cand) begin
          w_candProx = w_sinc;
          w_cntProx  = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_estadoProx = PRESSIONADO;
          if (habilita) begin
            if ($onehot(r_cand)) w_aceita = 1'b1;
            else                 w_erro   = 1'b1;
          end
        end else begin
          w_cntProx = r_cnt + CNT_UM;
        end
      end
      PRESSIONADO: begin
        if (w_sinc == '0) begin
          w_cntProx    = '0;
          w_estadoProx = FILTRA_SOLTA;
        end
      end
      FILTRA_SOLTA: begin
        if (w_sinc != '0) begin
          w_estadoProx = PRESSIONADO;
        end else if (r_cnt == CNT_MAX) begin
          w_estadoProx = OCIOSO;
        end else begin
          w_cntProx = r_cnt + CNT_UM;
        end
      end
      default: w_estadoProx = OCIOSO;
    endcase
  end

  // An accepted press overrides a simultaneous clear.
  always_comb begin
    w_jogadaProx = r_jogada;
    if (limpa)    w_jogadaProx = '0;
    if (w_aceita) w_jogadaProx = r_cand;
  end

  assign jogada        = r_jogada;
  assign jogada_feita  = r_jogadaFeita;
  assign erro_multiplo = r_erroMultiplo;
  assign db_estado     = r_estado;

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Input conditioning stage directly upstream of the game datapath.
- Converts the four raw, asynchronous, bouncing push-buttons into three signals that the datapath's jogada register and the control unit's jogada input consume:
  - a clean, held 4-bit one-hot play code;
  - a single-cycle jogada_feita pulse per valid press;
  - debug signals.
- Rejects multi-button presses.
- Suppresses plays while the game is not accepting input.

Parameters:
- DEBOUNCE_CYCLES, 50000, cycles the synchronized input must stay unchanged before a press or release is accepted (1 ms at 50 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- botoes  in  4  raw button inputs, active-high, asynchronous to clock
- habilita  in  1  game accepting plays; when 0, no pulse and no register update
- limpa  in  1  synchronous clear of the held play code (driven with zeraR)
- jogada  out  4  last valid one-hot play; 0000 after reset or limpa
- jogada_feita  out  1  one-cycle pulse per accepted press
- erro_multiplo  out  1  one-cycle pulse when a debounced press is not one-hot
- db_estado  out  4  FSM state code for hexa7seg display

Behaviour:
- Synchronizer:
  - Two flip-flops per bit, output s[3:0].
  - Reset value 0000.
  - All FSM decisions use s only.
- FSM states (db_estado codes):
  - OCIOSO = 0, FILTRA_PRESS = 1, PRESSIONADO = 2, FILTRA_SOLTA = 3.
  - Unused codes return to OCIOSO.
- Registers: candidate cand[3:0] and counter cnt[CNT_W-1:0].
- OCIOSO:
  - If s != 0: cand <= s, cnt <= 0, go to FILTRA_PRESS.
- FILTRA_PRESS:
  - If s == 0: go to OCIOSO.
  - Else if s != cand: cand <= s, cnt <= 0, stay (restart filter).
  - Else if cnt == DEBOUNCE_CYCLES-1: go to PRESSIONADO.
    - cand one-hot and habilita=1: jogada <= cand, jogada_feita = 1 on the following cycle.
    - cand not one-hot: erro_multiplo = 1 on the following cycle; jogada unchanged.
    - habilita=0: both pulses suppressed; jogada unchanged.
  - Else: cnt++.
- PRESSIONADO:
  - If s == 0: cnt <= 0, go to FILTRA_SOLTA.
  - Otherwise stay; changes between buttons while held never generate a pulse.
- FILTRA_SOLTA:
  - If s != 0: go to PRESSIONADO (bounce; no pulse).
  - Else if cnt == DEBOUNCE_CYCLES-1: go to OCIOSO.
  - Else: cnt++.
- Output timing:
  - jogada_feita and erro_multiplo are registered, exactly one cycle wide, never both high.
  - Latency: a clean press stable from edge 0 gives jogada_feita high during the cycle after edge DEBOUNCE_CYCLES+3.
  - jogada updates on the same edge that raises jogada_feita.
- limpa:
  - Sets jogada <= 0000 at the next edge; FSM unaffected.
  - If limpa coincides with an accepted press, the press wins: jogada = cand, pulse issued.
- habilita:
  - Sampled only at the accept edge.
  - A press held across a 0→1 transition of habilita never fires; the button must be released and pressed again.
- Reset (any time, including mid-filter):
  - State OCIOSO; s, cand, cnt, jogada = 0.
  - jogada_feita, erro_multiplo = 0.
  - A button held through reset release is debounced as a new press.

Decomposition:
- Shared package condicionador_pkg:
  - state encodings OCIOSO..FILTRA_SOLTA as 4-bit constants;
  - BOTOES_W = 4.
- One sub-module, sincronizador_2ff:
  - parameterized width, two-flop synchronizer;
  - reset to 0 on asynchronous reset.
- FSM, counter and output registers stay in condicionador_botoes.

Test Plan (DEBOUNCE_CYCLES = 4, habilita = 1 unless stated):
1. Clean press: botoes=0100 held 20 cycles, then 0000 → one jogada_feita pulse exactly 7 edges after the press; jogada=0100 afterwards; db_estado sequence 0,1,2,3,0.
2. Bounce: botoes toggles 0010/0000 every 2 cycles for 10 cycles, then steady 0010 → no pulse during toggling; exactly one pulse 7 edges after the input settles; release bounces produce no second pulse.
3. Multi-press: botoes=0011 held 10 cycles → erro_multiplo single pulse, jogada_feita stays 0, jogada keeps its prior value 0100.
4. Disabled then enabled: habilita=0, press 1000 held; raise habilita mid-hold; release; press 1000 again → no pulse for the first press, one pulse for the second, jogada=1000.
5. limpa and collision: jogada=0001, pulse limpa → jogada=0000 next cycle; then assert limpa on the accept edge of press 0001 → jogada=0001, jogada_feita=1.
6. Async reset mid-filter: assert reset in FILTRA_PRESS between clock edges → all outputs 0 and db_estado=0 immediately; button still held at release → new full-length debounce, then pulse.
